// File: rtl/vga_fb_fetch.sv
// Frame-buffer fetch engine: issues fixed-length AXI4 INCR read bursts over a linear
// frame and buffers the returned 64-bit words in a first-word-fall-through FIFO.
module vga_fb_fetch #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   fb_base,
  input  logic [23:0]                   frame_words,
  input  logic                          frame_start,
  output logic [3:0]                    arid,
  output logic [31:0]                   araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [63:0]                   rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rvalid,
  input  logic                          rlast,
  output logic [63:0]                   pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          resp_err
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN);

  localparam logic [LvlW-1:0]  MaxLvl     = LvlW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [BeatW-1:0] LastBeat   = BeatW'(BURST_LEN - 1);
  localparam logic [23:0]      BurstWords = 24'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StData, StDrain} state_e;

  state_e            state_q, state_d;
  logic [23:0]       word_idx_q, word_idx_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [31:0]       addr_q, addr_d;
  logic              abort_q, abort_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              underflow_q, underflow_d;
  logic              resp_err_q, resp_err_d;
  logic [63:0]       mem_q [FIFO_DEPTH];

  logic        push, push_en, pop;
  logic [23:0] idx_inc;
  logic [31:0] idx_addr;
  logic        unused_rlast;

  // Bursts end on the internal beat count only.
  assign unused_rlast = rlast;

  assign arid    = 4'd0;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'd3;
  assign arburst = 2'b01;

  assign idx_inc  = word_idx_q + BurstWords;
  assign idx_addr = fb_base + {5'b0, word_idx_q, 3'b000};

  // Address is frozen while the request is pending, even if frame_start clears word_idx.
  assign araddr  = (state_q == StReq) ? addr_q : idx_addr;
  assign arvalid = (state_q == StReq);

  assign pix_valid  = (level_q != '0);
  assign pix_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign underflow  = underflow_q;
  assign resp_err   = resp_err_q;

  assign pop     = pix_valid && pix_ready;
  assign push_en = push && !frame_start;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    abort_d    = abort_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && (level_q <= MaxLvl) && !frame_start) begin
          state_d = StReq;
          addr_d  = idx_addr;
        end
      end
      StReq: begin
        if (arready) begin
          beat_d  = '0;
          abort_d = 1'b0;
          if (frame_start || abort_q) begin
            state_d = StDrain;
          end else begin
            state_d    = StData;
            word_idx_d = (idx_inc == frame_words) ? 24'd0 : idx_inc;
          end
        end else if (frame_start) begin
          abort_d = 1'b1;
        end
      end
      StData: begin
        if (rvalid) begin
          push   = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end else if (frame_start) begin
            state_d = StDrain;
          end
        end else if (frame_start) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      word_idx_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    underflow_d = enable && pix_ready && !pix_valid;
    resp_err_d  = resp_err_q;
    if (frame_start) begin
      resp_err_d = 1'b0;
    end else if (rvalid && (rresp != 2'b00) && (state_q != StDrain)) begin
      resp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      abort_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      abort_q     <= abort_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Storage needs no reset: reads are qualified by level_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch: the bench plays the AXI read slave and the scan-out sink.
module tb_vga_fb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] fb_base;
  logic [23:0] frame_words;
  logic        frame_start;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic [63:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [6:0]  fifo_level;
  logic        underflow;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  vga_fb_fetch #(
    .BURST_LEN  (16),
    .FIFO_DEPTH (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fb_base     (fb_base),
    .frame_words (frame_words),
    .frame_start (frame_start),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rlast       (rlast),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .fifo_level  (fifo_level),
    .underflow   (underflow),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'h5A5A_0000 + 32'(k), 32'h8000_0000 + 32'(k * 8)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for arvalid, checks the address, then lets the handshake edge pass.
  task automatic wait_ar(input logic [31:0] exp_addr, input string tag);
    int n = 0;
    while (!arvalid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    check({tag, "_araddr"}, 64'(araddr), 64'(exp_addr));
    step();
  endtask

  task automatic send_beats(input int n, input int start, input logic [1:0] bad, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = pat(start + i);
      rresp  = (i == bad_idx) ? bad : 2'b00;
      step();
    end
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic quiet(input int n, input string tag);
    int seen = 0;
    repeat (n) begin
      step();
      if (arvalid) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    fb_base     = 32'h8000_0000;
    frame_words = 24'd64;
    frame_start = 1'b0;
    arready     = 1'b1;
    rdata       = '0;
    rresp       = 2'b00;
    rvalid      = 1'b0;
    rlast       = 1'b0;
    pix_ready   = 1'b0;
    step();
    step();

    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'h8000_0000);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("const_ar", 64'({arid, arlen, arsize, arburst}), 64'({4'd0, 8'd15, 3'd3, 2'b01}));

    // Four bursts fill the FIFO, then nothing more fits.
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_ar(32'h8000_0000 + 32'(b * 128), $sformatf("fill%0d", b));
      send_beats(16, b * 16, 2'b00, -1);
    end
    check("fill_level", 64'(fifo_level), 64'd64);
    quiet(10, "no_fifth_ar");

    // Pop down to 49: still no room for a burst.
    for (int i = 0; i < 15; i++) begin
      check($sformatf("pop_data%0d", i), pix_data, pat(i));
      pix_ready = 1'b1;
      step();
    end
    pix_ready = 1'b0;
    quiet(5, "lvl49_no_ar");
    check("lvl49", 64'(fifo_level), 64'd49);

    check("pop_data15", pix_data, pat(15));
    pix_ready = 1'b1;
    step();
    pix_ready = 1'b0;
    check("lvl48", 64'(fifo_level), 64'd48);
    check("lvl48_ar_not_yet", 64'(arvalid), 64'd0);
    step();
    check("lvl48_ar_rise", 64'(arvalid), 64'd1);
    wait_ar(32'h8000_0000, "wrap");
    send_beats(16, 64, 2'b00, -1);
    check("wrap_level", 64'(fifo_level), 64'd64);

    // Restart while idle, then restart mid-burst after beat 5.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("flush_idle_level", 64'(fifo_level), 64'd0);
    wait_ar(32'h8000_0000, "rs");
    send_beats(5, 0, 2'b00, -1);
    check("rs_level5", 64'(fifo_level), 64'd5);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("rs_flush_level", 64'(fifo_level), 64'd0);
    check("rs_flush_valid", 64'(pix_valid), 64'd0);
    send_beats(11, 100, 2'b10, 0);
    check("drain_no_push", 64'(fifo_level), 64'd0);
    check("drain_no_err", 64'(resp_err), 64'd0);
    wait_ar(32'h8000_0000, "restart");
    send_beats(16, 0, 2'b00, -1);
    check("restart_head", pix_data, pat(0));
    check("restart_level", 64'(fifo_level), 64'd16);

    // Push and pop every cycle; enable drops mid-burst and the burst still completes.
    wait_ar(32'h8000_0080, "pp");
    enable    = 1'b0;
    pix_ready = 1'b1;
    send_beats(16, 16, 2'b00, -1);
    pix_ready = 1'b0;
    check("pp_level", 64'(fifo_level), 64'd16);
    check("pp_head", pix_data, pat(16));
    quiet(5, "disabled_no_ar");

    // Underflow: one-cycle sink request while empty.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    arready   = 1'b0;
    enable    = 1'b1;
    pix_ready = 1'b1;
    step();
    check("uf_pulse", 64'(underflow), 64'd1);
    pix_ready = 1'b0;
    step();
    check("uf_clear", 64'(underflow), 64'd0);
    check("req_held", 64'(arvalid), 64'd1);

    // Reset while a request is pending with data in the FIFO.
    arready = 1'b1;
    wait_ar(32'h8000_0000, "pre_rst");
    arready = 1'b0;
    send_beats(16, 0, 2'b00, -1);
    step();
    step();
    check("pre_rst_req", 64'(arvalid), 64'd1);
    check("pre_rst_level", 64'(fifo_level), 64'd16);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_araddr", 64'(araddr), 64'h8000_0000);

    // Sticky response error, cleared only by frame_start.
    arready = 1'b1;
    wait_ar(32'h8000_0000, "err");
    enable = 1'b0;
    send_beats(16, 0, 2'b10, 3);
    check("err_set", 64'(resp_err), 64'd1);
    quiet(3, "err_no_ar");
    check("err_sticky", 64'(resp_err), 64'd1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("err_cleared", 64'(resp_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
